ahb_apb_bridge_param: RTL and testbench

Parametrised AHB-to-APB bridge with a configurable number of APB slaves, data/address widths, APB wait-state support (`pready`), slave error reporting (`pslverr` mapped to a two-cycle AHB ERROR response), and an optional `pready` timeout. It sits between an AHB master and an APB slave group, and replaces the fixed 3-slave, zero-wait bridge in the same test topology. One AHB transfer maps to exactly one APB transfer, with no pipelining across transfers.

---
 rtl/ahb_apb_bridge_param.sv | 192 +++++++++++++++++++
 tb/tb_ahb_apb_bridge_param.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge_param.sv
// ahb_apb_bridge_param
//   Parametrised AHB-to-APB bridge. Each accepted AHB transfer becomes exactly
//   one APB transfer (SETUP then ACCESS). APB wait states are driven by pready.
//   A slave error, or a pready timeout, becomes a two-cycle AHB ERROR response.
//   An unmapped address gets the ERROR response without any APB cycle.
//
// Ports
//   hclk, hreset        : clock, synchronous active-high reset
//   hwrite, hreadyin    : AHB direction and bus-ready inputs
//   htrans, haddr       : AHB transfer type and address (address phase)
//   hwdata              : AHB write data (data phase)
//   prdata, pready      : APB read data, ready from the selected slave
//   pslverr             : APB slave error, qualified by pready
//   hrdata, hreadyout   : AHB read data and ready back to the master
//   hresp               : AHB response, 00 OKAY / 01 ERROR
//   pwrite, penable     : APB direction and enable
//   pselx               : one-hot APB slave select
//   paddr, pwdata       : APB address and write data
module ahb_apb_bridge_param #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLAVES = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                REGION_W   = 26,
    parameter int                TIMEOUT    = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hwrite,
    input  logic                  hreadyin,
    input  logic [1:0]            htrans,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [DATA_W-1:0]     hwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [DATA_W-1:0]     hrdata,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic                  pwrite,
    output logic                  penable,
    output logic [NUM_SLAVES-1:0] pselx,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]     offset;
    logic [ADDR_W-1:0]     region;
    logic                  mapped;
    logic                  accept;
    logic                  timeout_hit;
    logic [IDX_W-1:0]      idx_dec;
    logic [IDX_W-1:0]      slave_idx;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_d;
    logic                  hreadyout_d;
    logic [1:0]            hresp_d;
    logic                  penable_d;
    logic                  pwrite_d;
    logic [NUM_SLAVES-1:0] pselx_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [DATA_W-1:0]     pwdata_d;
    logic [DATA_W-1:0]     hrdata_d;

    // SEQ and NONSEQ are treated alike, so only htrans[1] matters.
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // Only the IDLE state takes a new transfer; BUSY/IDLE htrans are ignored.
    assign accept = (state == ST_IDLE) && hreadyin && hreadyout && htrans[1];

    // Region index = (haddr - BASE_ADDR) >> REGION_W. Addresses below the base
    // wrap to a huge offset, so they need their own unmapped test.
    assign offset  = haddr - BASE_ADDR;
    assign region  = offset >> REGION_W;
    assign mapped  = (haddr >= BASE_ADDR) && (region < ADDR_W'(NUM_SLAVES));
    assign idx_dec = region[IDX_W-1:0];

    // Counter holds the number of ACCESS cycles already completed, so the
    // TIMEOUT-th ACCESS cycle is the one where it reads TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // State register plus the registered outputs computed by the output logic.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            slave_idx <= '0;
            cnt       <= '0;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pselx     <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            hrdata    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_d;
            hreadyout <= hreadyout_d;
            hresp     <= hresp_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            pselx     <= pselx_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            hrdata    <= hrdata_d;
            if (accept) begin
                slave_idx <= idx_dec;
            end
        end
    end

    // Next-state logic. In ACCESS a pready in the final timeout cycle still
    // wins, because the pready checks come before the timeout check.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = mapped ? ST_LATCH : ST_ERR1;
                end
            end
            ST_LATCH:  state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (pready && !pslverr) begin
                    state_next = ST_IDLE;
                end else if (pready || timeout_hit) begin
                    state_next = ST_ERR1;
                end
            end
            ST_ERR1:   state_next = ST_ERR2;
            ST_ERR2:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: the values each output takes in the state being entered,
    // so that every bus output comes straight from a flop.
    always_comb begin
        hreadyout_d = (state_next == ST_IDLE) || (state_next == ST_ERR2);
        hresp_d     = ((state_next == ST_ERR1) || (state_next == ST_ERR2)) ? 2'b01 : 2'b00;
        penable_d   = (state_next == ST_ACCESS);
        pselx_d     = '0;
        if ((state_next == ST_SETUP) || (state_next == ST_ACCESS)) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                pselx_d[i] = (slave_idx == IDX_W'(i));
            end
        end

        paddr_d  = paddr;
        pwrite_d = pwrite;
        if (accept) begin
            paddr_d  = haddr;
            pwrite_d = hwrite;
        end

        // hwdata is valid in the data phase, which is the LATCH cycle.
        pwdata_d = pwdata;
        if ((state == ST_LATCH) && pwrite) begin
            pwdata_d = hwdata;
        end

        hrdata_d = hrdata;
        if ((state == ST_ACCESS) && pready && !pslverr && !pwrite) begin
            hrdata_d = prdata;
        end

        cnt_d = cnt;
        if (state == ST_LATCH) begin
            cnt_d = '0;
        end else if (state == ST_ACCESS) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// tb_ahb_apb_bridge_param
//   Scoreboard bench for ahb_apb_bridge_param (3 slaves, TIMEOUT=4). The
//   driver pushes the expected AHB completion and APB transfer into queues;
//   two monitors pop and compare whenever the bus shows a completion.
module tb_ahb_apb_bridge_param;

    localparam int TOUT = 4;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hwrite = 1'b0;
    logic        hreadyin = 1'b1;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    ahb_apb_bridge_param #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_SLAVES(3),
        .BASE_ADDR (32'h8000_0000),
        .REGION_W  (26),
        .TIMEOUT   (TOUT)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .hwrite   (hwrite),
        .hreadyin (hreadyin),
        .htrans   (htrans),
        .haddr    (haddr),
        .hwdata   (hwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .hrdata   (hrdata),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .pwrite   (pwrite),
        .penable  (penable),
        .pselx    (pselx),
        .paddr    (paddr),
        .pwdata   (pwdata)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          addr_cyc;
    } ahb_exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          acc;
    } apb_exp_t;

    ahb_exp_t    ahb_q[$];
    apb_exp_t    apb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model_hrdata = '0;
    logic [31:0] model_pwdata = '0;

    int          slave_waits = 0;
    logic        slave_err = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          acc_idx = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    // APB slave model: pready rises in ACCESS cycle number slave_waits (0-based).
    always @(negedge hclk) begin
        if (penable === 1'b1 && pselx !== 3'b000) begin
            pready  = (acc_idx == slave_waits);
            pslverr = slave_err && (acc_idx == slave_waits);
            acc_idx = acc_idx + 1;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            acc_idx = 0;
        end
        prdata = slave_rdata;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AHB monitor: a rising hreadyout ends a transfer (OKAY or ERROR pair).
    logic       prev_ready = 1'b1;
    logic [1:0] prev_resp = 2'b00;
    initial begin
        ahb_exp_t e;
        forever begin
            @(negedge hclk);
            #1;
            if (hreset) begin
                prev_ready = 1'b1;
                prev_resp  = 2'b00;
            end else begin
                if (hreadyout === 1'b1 && prev_ready === 1'b0) begin
                    if (ahb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL ahb_unexpected_done: got completion at cycle %0d, required none", cyc);
                    end else begin
                        e = ahb_q.pop_front();
                        check_output("ahb_hresp", 32'(hresp), e.err ? 32'd1 : 32'd0);
                        if (e.err) check_output("ahb_err_first_cycle", 32'(prev_resp), 32'd1);
                        check_output("ahb_hrdata", hrdata, e.rdata);
                        check_output("ahb_latency", cyc - e.addr_cyc, e.lat);
                    end
                end
                prev_ready = hreadyout;
                prev_resp  = hresp;
            end
        end
    end

    // APB monitor: compares each completed APB transfer (pready in ACCESS).
    int setup_cnt = 0;
    int acc_cnt = 0;
    initial begin
        apb_exp_t a;
        forever begin
            @(negedge hclk);
            #1;
            if (hreset || pselx === 3'b000) begin
                setup_cnt = 0;
                acc_cnt   = 0;
            end else if (penable === 1'b0) begin
                setup_cnt++;
            end else begin
                acc_cnt++;
                if (pready) begin
                    if (apb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL apb_unexpected: got pselx=%b paddr=%h, required no transfer", pselx, paddr);
                    end else begin
                        a = apb_q.pop_front();
                        check_output("apb_pselx", 32'(pselx), 32'(a.sel));
                        check_output("apb_paddr", paddr, a.addr);
                        check_output("apb_pwrite", 32'(pwrite), 32'(a.wr));
                        check_output("apb_pwdata", pwdata, a.wdata);
                        check_output("apb_setup_cycles", setup_cnt, 1);
                        check_output("apb_access_cycles", acc_cnt, a.acc);
                    end
                    setup_cnt = 0;
                    acc_cnt   = 0;
                end
            end
        end
    end

    // Issue one AHB transfer once the bridge is IDLE, and queue what it should do.
    task automatic apply_stimulus(
        input logic [1:0]  trans,
        input logic [31:0] addr,
        input logic        wr,
        input logic [31:0] wdata,
        input int          waits,
        input logic        slv_err,
        input logic [31:0] rdata,
        input logic [2:0]  sel,
        input bit          apb_done,
        input bit          exp_ahb,
        input bit          exp_err,
        input int          lat
    );
        int       n;
        ahb_exp_t e;
        apb_exp_t a;
        n = 0;
        @(negedge hclk);
        while (!(hreadyout === 1'b1 && hresp === 2'b00) && n < 100) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_wait: got no IDLE within 100 cycles, required IDLE before %h", addr);
            return;
        end
        slave_waits = waits;
        slave_err   = slv_err;
        slave_rdata = rdata;
        htrans      = trans;
        haddr       = addr;
        hwrite      = wr;
        hwdata      = ~wdata;
        if (apb_done && wr) model_pwdata = wdata;
        if (apb_done && !wr && !slv_err) model_hrdata = rdata;
        if (apb_done) begin
            a.sel   = sel;
            a.addr  = addr;
            a.wr    = wr;
            a.wdata = model_pwdata;
            a.acc   = waits + 1;
            apb_q.push_back(a);
        end
        if (exp_ahb) begin
            e.err      = exp_err;
            e.rdata    = model_hrdata;
            e.lat      = lat;
            e.addr_cyc = cyc;
            ahb_q.push_back(e);
        end
        @(posedge hclk);
        #1;
        htrans = 2'b00;
        hwdata = wdata;
    endtask

    initial begin
        int n;
        logic [1:0] idle_trans [4];
        logic       idle_rdy   [4];
        idle_trans = '{2'b00, 2'b01, 2'b10, 2'b11};
        idle_rdy   = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset for two cycles with IDLE on the bus.
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        check_output("rst_hreadyout", 32'(hreadyout), 32'd1);
        check_output("rst_hresp", 32'(hresp), 32'd0);
        check_output("rst_hrdata", hrdata, 32'd0);
        check_output("rst_pselx", 32'(pselx), 32'd0);
        check_output("rst_penable", 32'(penable), 32'd0);
        check_output("rst_pwrite", 32'(pwrite), 32'd0);
        check_output("rst_paddr", paddr, 32'd0);
        check_output("rst_pwdata", pwdata, 32'd0);
        hreset = 1'b0;

        // IDLE, BUSY, and NONSEQ/SEQ with hreadyin low must not start a transfer.
        for (int i = 0; i < 4; i++) begin
            htrans   = idle_trans[i];
            hreadyin = idle_rdy[i];
            haddr    = 32'h8000_0000;
            @(negedge hclk);
            check_output("idle_pselx", 32'(pselx), 32'd0);
            check_output("idle_hreadyout", 32'(hreadyout), 32'd1);
        end
        htrans   = 2'b00;
        hreadyin = 1'b1;

        // Single zero-wait write to slave 1.
        apply_stimulus(2'b10, 32'h8400_0010, 1'b1, 32'hA5A5_1234, 0, 1'b0, 32'h0,
                       3'b010, 1'b1, 1'b1, 1'b0, 4);
        // Read from slave 2 with pready low for 3 cycles (pready in the last timeout cycle).
        apply_stimulus(2'b10, 32'h8800_0004, 1'b0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF,
                       3'b100, 1'b1, 1'b1, 1'b0, 7);
        // INCR4 write burst, back-to-back.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus((k == 0) ? 2'b10 : 2'b11, 32'h8000_0000 + 32'(4 * k), 1'b1,
                           32'h1000_0000 + 32'(k), 0, 1'b0, 32'h0,
                           3'b001, 1'b1, 1'b1, 1'b0, 4);
        end
        // Slave error on a read: ERROR pair, hrdata keeps the last good read.
        apply_stimulus(2'b10, 32'h8400_0020, 1'b0, 32'h0, 0, 1'b1, 32'h1111_2222,
                       3'b010, 1'b1, 1'b1, 1'b1, 5);
        // Slave error on a write after two wait cycles.
        apply_stimulus(2'b10, 32'h8000_0100, 1'b1, 32'h7777_8888, 2, 1'b1, 32'h0,
                       3'b001, 1'b1, 1'b1, 1'b1, 7);
        // Unmapped: just past the last slave, and just below the base.
        apply_stimulus(2'b10, 32'h8C00_0000, 1'b1, 32'h3333_4444, 0, 1'b0, 32'h0,
                       3'b000, 1'b0, 1'b1, 1'b1, 2);
        apply_stimulus(2'b10, 32'h7FFF_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'h5555_6666,
                       3'b000, 1'b0, 1'b1, 1'b1, 2);
        // Last word of slave 2 is still mapped.
        apply_stimulus(2'b10, 32'h8BFF_FFFC, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_0001,
                       3'b100, 1'b1, 1'b1, 1'b0, 5);
        // pready never arrives: ERR1 after 4 ACCESS cycles.
        apply_stimulus(2'b10, 32'h8000_0008, 1'b0, 32'h0, 99, 1'b0, 32'h9999_9999,
                       3'b001, 1'b0, 1'b1, 1'b1, 8);

        // Reset during ACCESS: no response, everything back to reset values.
        apply_stimulus(2'b10, 32'h8000_000C, 1'b0, 32'h0, 99, 1'b0, 32'h4242_4242,
                       3'b001, 1'b0, 1'b0, 1'b0, 0);
        n = 0;
        @(negedge hclk);
        while (penable !== 1'b1 && n < 20) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL access_wait: got penable=%b, required ACCESS within 20 cycles", penable);
        end
        hreset = 1'b1;
        @(negedge hclk);
        check_output("midrst_pselx", 32'(pselx), 32'd0);
        check_output("midrst_penable", 32'(penable), 32'd0);
        check_output("midrst_hreadyout", 32'(hreadyout), 32'd1);
        check_output("midrst_hresp", 32'(hresp), 32'd0);
        check_output("midrst_hrdata", hrdata, 32'd0);
        @(posedge hclk);
        #1;
        hreset       = 1'b0;
        model_hrdata = '0;
        model_pwdata = '0;

        // Normal traffic after the reset.
        apply_stimulus(2'b10, 32'h8000_0040, 1'b1, 32'h0BAD_F00D, 0, 1'b0, 32'h0,
                       3'b001, 1'b1, 1'b1, 1'b0, 4);
        apply_stimulus(2'b10, 32'h8400_0000, 1'b0, 32'h0, 0, 1'b0, 32'h5A5A_0F0F,
                       3'b010, 1'b1, 1'b1, 1'b0, 4);

        // Let the monitors drain the queues, then make sure nothing was dropped.
        n = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0) && n < 50) begin
            @(negedge hclk);
            n++;
        end
        repeat (3) @(negedge hclk);
        check_output("ahb_queue_left", ahb_q.size(), 32'd0);
        check_output("apb_queue_left", apb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
